// File: rtl/mux_sel_arbiter.sv
// Purpose : round-robin burst arbiter driving the select of a 1-bit 2:1 mux
//           (C = sel ? B : A), plus a registered copy of the selected bit.
// Latency : 1 cycle from data on the selected input to dout/dout_vld.
// Backpr. : none downstream; requesters are level-sensitive and are held off
//           simply by not being granted (no credits, no stall of dout).
//
// Ports
//   clk              rising-edge clock for all state
//   rst_n            synchronous, active-low reset
//   req_a / req_b    level-sensitive channel requests
//   data_a / data_b  serial data bits (the mux's A and B inputs)
//   sel              mux select, 0 = A, 1 = B (registered state decode only)
//   gnt_a / gnt_b    channel holds the grant this cycle
//   dout / dout_vld  selected bit, one cycle late, with its valid flag
//   busy             a grant (or parity slot) is in progress
//
// Build option
//   MUX_ARB_PARITY_EN : after a burst that runs its full BURST length, insert
//   one PAR slot that emits the even parity (XOR) of that burst's data bits
//   on dout. Undefined by default; the default build has no PAR state and no
//   parity accumulator.

module mux_sel_arbiter #(
    parameter int unsigned BURST = 4,  // max consecutive granted cycles, 1..2^CNT_W-1
    parameter int unsigned CNT_W = 3   // burst counter width
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic data_a,
    input  logic data_b,
    output logic sel,
    output logic gnt_a,
    output logic gnt_b,
    output logic dout,
    output logic dout_vld,
    output logic busy
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
`ifdef MUX_ARB_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2,
        ST_PAR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;
`endif

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             last_q,  last_d;      // last burst owner: 0 = A, 1 = B
    logic             dout_q,  dout_d;
    logic             dout_vld_q, dout_vld_d;
`ifdef MUX_ARB_PARITY_EN
    logic             par_q,   par_d;       // running XOR of the current burst
`endif

    // ------------------------------------------------------------------
    // Shared arbitration decision.
    // 'owner_b' is whoever most recently held (or is ending) the grant.
    // The other channel gets priority so bursts alternate without a bubble;
    // failing that the owner is re-granted; otherwise go idle.
    // In IDLE the same rule with owner = last gives the round-robin tie
    // break (the channel that did not go last wins).
    // ------------------------------------------------------------------
    function automatic state_t next_grant(input logic owner_b,
                                          input logic ra,
                                          input logic rb);
        logic other_req;
        logic own_req;
        other_req = owner_b ? ra : rb;
        own_req   = owner_b ? rb : ra;
        if (other_req) begin
            next_grant = owner_b ? ST_GNT_A : ST_GNT_B;
        end else if (own_req) begin
            next_grant = owner_b ? ST_GNT_B : ST_GNT_A;
        end else begin
            next_grant = ST_IDLE;
        end
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic   owner_b;     // current grant belongs to B
    logic   owner_req;   // owner still requesting at this edge
    logic   sel_bit;     // the bit currently on the mux output
    state_t arb_nxt;

    always_comb begin
        owner_b    = (state_q == ST_GNT_B);
        owner_req  = owner_b ? req_b  : req_a;
        sel_bit    = owner_b ? data_b : data_a;

        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        dout_d     = dout_q;      // dout holds whenever no bit is emitted
        dout_vld_d = 1'b0;
        arb_nxt    = ST_IDLE;
`ifdef MUX_ARB_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                arb_nxt = next_grant(last_q, req_a, req_b);
                state_d = arb_nxt;
                cnt_d   = (arb_nxt == ST_IDLE) ? '0 : CNT_ONE;
            end

            ST_GNT_A, ST_GNT_B: begin
                if (!owner_req) begin
                    // Early release: this cycle's bit is dropped, not counted.
                    last_d  = owner_b;
                    arb_nxt = next_grant(owner_b, req_a, req_b);
                    state_d = arb_nxt;
                    cnt_d   = (arb_nxt == ST_IDLE) ? '0 : CNT_ONE;
`ifdef MUX_ARB_PARITY_EN
                    par_d   = 1'b0;
`endif
                end else begin
                    dout_d     = sel_bit;
                    dout_vld_d = 1'b1;
                    if (cnt_q == BURST_C) begin
                        last_d = owner_b;
`ifdef MUX_ARB_PARITY_EN
                        // Full burst: fold in the final bit and emit parity next.
                        par_d   = par_q ^ sel_bit;
                        state_d = ST_PAR;
                        cnt_d   = '0;
`else
                        arb_nxt = next_grant(owner_b, req_a, req_b);
                        state_d = arb_nxt;
                        cnt_d   = (arb_nxt == ST_IDLE) ? '0 : CNT_ONE;
`endif
                    end else begin
`ifdef MUX_ARB_PARITY_EN
                        par_d = par_q ^ sel_bit;
`endif
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

`ifdef MUX_ARB_PARITY_EN
            ST_PAR: begin
                // last_q already names the owner of the burst just finished.
                dout_d     = par_q;
                dout_vld_d = 1'b1;
                par_d      = 1'b0;
                arb_nxt    = next_grant(last_q, req_a, req_b);
                state_d    = arb_nxt;
                cnt_d      = (arb_nxt == ST_IDLE) ? '0 : CNT_ONE;
            end
`endif

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers, synchronous active-low reset.
    // Reset sets last = B so that A wins the first tie.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
`ifdef MUX_ARB_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
`ifdef MUX_ARB_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs, decoded from the state register only so that sel
    // never glitches with the request inputs.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_a = (state_q == ST_GNT_A);
        gnt_b = (state_q == ST_GNT_B);
        busy  = (state_q != ST_IDLE);
`ifdef MUX_ARB_PARITY_EN
        sel   = (state_q == ST_GNT_B) || ((state_q == ST_PAR) && last_q);
`else
        sel   = (state_q == ST_GNT_B);
`endif
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Purpose : directed self-checking bench for mux_sel_arbiter (BURST=4, default build).
// Latency : outputs are sampled 2 time units after each rising edge.
// Backpr. : not applicable; requests are driven directly.

module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic req_a, req_b, data_a, data_b;
    logic sel, gnt_a, gnt_b, dout, dout_vld, busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(
        .BURST (4),
        .CNT_W (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .req_b    (req_b),
        .data_a   (data_a),
        .data_b   (data_b),
        .sel      (sel),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy)
    );

    // Output vector order: {sel, gnt_a, gnt_b, dout, dout_vld, busy}
    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {sel,ga,gb,dout,vld,busy}=%b expected %b", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, clock it, then compare the post-edge outputs.
    task automatic step(input string tag, input logic ra, input logic rb,
                        input logic da, input logic db, input logic [5:0] exp);
        req_a  = ra;
        req_b  = rb;
        data_a = da;
        data_b = db;
        @(posedge clk);
        #2;
        chk(tag, {sel, gnt_a, gnt_b, dout, dout_vld, busy}, exp);
    endtask

    logic [8:0] a_bits;

    initial begin
        rst_n  = 1'b0;
        req_a  = 1'b1;
        req_b  = 1'b1;
        data_a = 1'b0;
        data_b = 1'b0;

        // Reset held with both requesting: everything low.
        step("rst0", 1, 1, 0, 0, 6'b000000);
        step("rst1", 1, 1, 0, 0, 6'b000000);
        rst_n = 1'b1;

        // First edge after release: tie, last=B, so A is granted.
        step("first_gnt", 1, 1, 1, 0, 6'b010001);

        // Contention: four A cycles, then straight into four B cycles.
        step("ctn_a1", 1, 1, 1, 0, 6'b010111);
        step("ctn_a2", 1, 1, 0, 0, 6'b010011);
        step("ctn_a3", 1, 1, 1, 0, 6'b010111);
        step("ctn_a4", 1, 1, 1, 0, 6'b101111);
        step("ctn_b1", 1, 1, 0, 0, 6'b101011);
        step("ctn_b2", 1, 1, 0, 1, 6'b101111);
        step("ctn_b3", 1, 1, 0, 1, 6'b101111);
        step("ctn_b4", 1, 1, 0, 0, 6'b010011);

        // A releases on its first cycle while B waits: bit dropped, hand to B.
        step("rel_a_to_b", 0, 1, 1, 0, 6'b101001);

        // B alone: full burst then re-grant with no bubble.
        step("solo_b1", 0, 1, 0, 1, 6'b101111);
        step("solo_b2", 0, 1, 0, 0, 6'b101011);
        step("solo_b3", 0, 1, 0, 1, 6'b101111);
        step("solo_b4", 0, 1, 0, 1, 6'b101111);
        step("solo_b1b", 0, 1, 0, 1, 6'b101111);

        // B drops at its 2nd granted cycle: idle, dout holds 1, not valid.
        step("rel_b_idle", 0, 0, 0, 0, 6'b000100);
        step("idle_hold", 0, 0, 1, 1, 6'b000100);

        // last=B after that release, so a tie grants A.
        step("tie_after_rel", 1, 1, 0, 0, 6'b010101);

        // A alone for nine cycles across a re-grant: dout follows data_a.
        a_bits = 9'b1_0010_1101;  // applied LSB first: 1,0,1,1,0,1,0,0,1
        for (int i = 0; i < 9; i++) begin
            step($sformatf("solo_a%0d", i), 1, 0, a_bits[i], 0,
                 {3'b010, a_bits[i], 2'b11});
        end

        // One more cycle puts A in the 3rd cycle of its burst.
        step("solo_a_c3", 1, 0, 1, 0, 6'b010111);

        // Reset mid-burst with both requesting: all outputs low.
        rst_n = 1'b0;
        step("rst_mid", 1, 1, 1, 1, 6'b000000);
        rst_n = 1'b1;

        // last was A before reset; reset restores last=B, so A wins the tie.
        step("post_rst_tie", 1, 1, 0, 0, 6'b010001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Upstream control stage for the 1-bit 2:1 mux (inputs A, B, select temp; output C = temp ? B : A).
- Arbitrates two bit-serial requesters, A and B, using round-robin bursts of up to BURST cycles.
- Drives the mux select and per-channel grants.
- Also provides a registered copy of the selected bit with a valid flag for the downstream consumer.

Parameters:
- BURST, 4, maximum consecutive cycles one channel holds the grant (legal range 1..2^CNT_W-1).
- CNT_W, 3, width of the burst counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_a  input  1  channel A request; level-sensitive.
- req_b  input  1  channel B request; level-sensitive.
- data_a  input  1  channel A serial bit; wired to mux input A.
- data_b  input  1  channel B serial bit; wired to mux input B.
- sel  output  1  mux select (drives temp); 0 selects A, 1 selects B.
- gnt_a  output  1  channel A granted this cycle.
- gnt_b  output  1  channel B granted this cycle.
- dout  output  1  registered selected bit.
- dout_vld  output  1  dout carries a valid bit.
- busy  output  1  a grant is active.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, cnt=0, last=B (so A wins the first tie).
  - sel=0, gnt_a=0, gnt_b=0, dout=0, dout_vld=0, busy=0.
  - A reset asserted mid-burst aborts the burst on that edge. No partial bit is flagged valid afterwards.
- States: IDLE, GNT_A, GNT_B. All outputs except dout and dout_vld are Moore, decoded from the state register.
- IDLE:
  - req_a & ~req_b -> GNT_A.
  - req_b & ~req_a -> GNT_B.
  - Both requesting -> grant the channel not equal to last.
  - Neither requesting -> stay in IDLE.
  - cnt loads 1 on entry to a grant state.
- GNT_A: gnt_a=1, sel=0, busy=1. GNT_B: gnt_b=1, sel=1, busy=1.
- Each cycle in a grant state, dout <= selected data bit and dout_vld <= 1 on the next edge. Latency is 1 cycle from data on the bus to dout.
- Grant end:
  - The burst ends when cnt==BURST, or when the owner's req is low at the sampling edge (early release).
  - On early release, that cycle's bit is not counted: dout_vld is 0 for that cycle.
  - At end of burst, last <= owner.
  - If the other channel is requesting, move directly to its grant state with no idle bubble.
  - Else if the owner still requests, re-grant the owner with cnt reloaded to 1.
  - Else go to IDLE.
- cnt increments by 1 per granted cycle and is compared at CNT_W width. It never wraps because BURST < 2^CNT_W.
- In IDLE, dout_vld=0 and dout holds its last value.
- sel changes only on clock edges; it is never combinationally derived from req.
- BURST=1 degenerates to strict per-cycle alternation when both channels request.

Optional Feature:
- Macro MUX_ARB_PARITY_EN.
- When defined:
  - Adds state PAR, entered after a burst ends normally at cnt==BURST.
  - In PAR: sel holds the owner's value, gnt is deasserted, busy=1.
  - dout = even parity (XOR) of the BURST data bits sent in that burst, with dout_vld=1 for one cycle.
  - Next-state arbitration then proceeds as above.
  - An early-released burst emits no parity cycle, and the parity accumulator clears.
- When undefined: no PAR state and no accumulator; behaviour exactly as above.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req_a=req_b=1 -> all outputs 0. First edge after release -> gnt_a=1, sel=0.
- Single requester: req_a=1 held, data_a=1,0,1,1,... with BURST=4 -> gnt_a continuous (re-grant, no bubble); dout follows data_a one cycle later; dout_vld=1 throughout.
- Contention: req_a=req_b=1 held -> gnt_a for 4 cycles, then gnt_b for 4, alternating; sel toggles 0->1 with no IDLE cycle between bursts.
- Early release: req_b drops at the 2nd granted cycle -> next edge returns to IDLE, busy=0, dout_vld=0; last=B, so a subsequent tie grants A.
- Reset mid-burst: rst_n=0 during the 3rd cycle of GNT_A -> next edge gives state IDLE, sel=0, dout_vld=0, cnt=0.
- MUX_ARB_PARITY_EN: BURST=4, data_a=1,1,0,1 -> after the 4 data bits, one PAR cycle with dout=1, dout_vld=1, gnt_a=0; then the next grant begins.
